// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with DE, HS, VS and frame pulses.
// Stopping is deferred to the end of the current frame so no partial frame ever leaves the block.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        enable,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        pixel_de,
  output logic        pixel_hs,
  output logic        pixel_vs,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  // state    | meaning
  // S_IDLE   | counters parked at (0,0), sync lines inactive
  // S_RUN    | scanning, enable held high
  // S_STOP   | scanning out the rest of the frame after enable dropped

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_geometry
    $error("video_timing_gen: illegal timing geometry");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic        r_de, r_hs, r_vs, r_fs, r_busy;
  logic [15:0] r_frame_cnt;
  logic        w_last, w_run_nxt, w_de_nxt, w_hs_nxt, w_vs_nxt, w_fs_nxt;

  assign w_last = (r_x == H_LAST) && (r_y == V_LAST);

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (enable) w_state_nxt = S_RUN;
      S_RUN, S_STOP: begin
        if (enable)      w_state_nxt = S_RUN;
        else if (w_last) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_STOP;
      end
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed for the position shown next cycle, then registered.
  always_comb begin
    w_run_nxt = (w_state_nxt != S_IDLE);
    w_x_nxt   = 12'd0;
    w_y_nxt   = 12'd0;
    if (r_state != S_IDLE && w_run_nxt && !w_last) begin
      if (r_x == H_LAST) begin
        w_y_nxt = r_y + 12'd1;
      end else begin
        w_x_nxt = r_x + 12'd1;
        w_y_nxt = r_y;
      end
    end
    w_de_nxt = w_run_nxt && (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
    w_hs_nxt = (w_run_nxt && w_x_nxt >= HS_BEG && w_x_nxt < HS_END) ? HS_POL : ~HS_POL;
    w_vs_nxt = (w_run_nxt && w_y_nxt >= VS_BEG && w_y_nxt < VS_END) ? VS_POL : ~VS_POL;
    w_fs_nxt = w_run_nxt && (w_x_nxt == 12'd0) && (w_y_nxt == 12'd0);
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_x         <= 12'd0;
      r_y         <= 12'd0;
      r_de        <= 1'b0;
      r_hs        <= ~HS_POL;
      r_vs        <= ~VS_POL;
      r_fs        <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_de   <= w_de_nxt;
      r_hs   <= w_hs_nxt;
      r_vs   <= w_vs_nxt;
      r_fs   <= w_fs_nxt;
      r_busy <= w_run_nxt;
      if (w_fs_nxt) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign pixel_de    = r_de;
  assign pixel_hs    = r_hs;
  assign pixel_vs    = r_vs;
  assign frame_start = r_fs;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a 14x7 raster (H 8/2/2/2, V 4/1/1/1, HS high, VS low).
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] px, py;
  logic        de, hs, vs, fs, bsy;
  logic [15:0] fcnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(en),
    .pixel_x(px), .pixel_y(py), .pixel_de(de), .pixel_hs(hs), .pixel_vs(vs),
    .frame_start(fs), .frame_cnt(fcnt), .busy(bsy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // idx is the raster position within a frame: x = idx % 14, y = idx / 14
  task automatic check_pos(input int idx);
    int ex, ey;
    ex = idx % 14;
    ey = idx / 14;
    chk($sformatf("x@%0d", idx), int'(px), ex);
    chk($sformatf("y@%0d", idx), int'(py), ey);
    chk($sformatf("de@%0d", idx), int'(de), (ex < 8 && ey < 4) ? 1 : 0);
    chk($sformatf("hs@%0d", idx), int'(hs), (ex >= 10 && ex < 12) ? 1 : 0);
    chk($sformatf("vs@%0d", idx), int'(vs), (ey == 5) ? 0 : 1);
    chk($sformatf("fs@%0d", idx), int'(fs), (idx == 0) ? 1 : 0);
    chk($sformatf("busy@%0d", idx), int'(bsy), 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_x"}, int'(px), 0);
    chk({tag, "_y"}, int'(py), 0);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_hs"}, int'(hs), 0);
    chk({tag, "_vs"}, int'(vs), 1);
    chk({tag, "_fs"}, int'(fs), 0);
    chk({tag, "_busy"}, int'(bsy), 0);
  endtask

  task automatic run_to(input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      step();
      check_pos(i);
    end
  endtask

  initial begin
    int n_de, n_hs, n_vslo;

    #12;
    check_idle("rst");
    chk("rst_fcnt", int'(fcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check_idle("idle_en0");

    // first frame, full raster walk
    en = 1'b1;
    n_de = 0; n_hs = 0; n_vslo = 0;
    for (int i = 0; i < 98; i++) begin
      step();
      check_pos(i);
      if (i == 0) chk("fcnt_first", int'(fcnt), 1);
      if (de) n_de++;
      if (hs) n_hs++;
      if (!vs) n_vslo++;
    end
    chk("de_per_frame", n_de, 32);
    chk("hs_per_frame", n_hs, 14);
    chk("vslo_per_frame", n_vslo, 14);
    step();
    check_pos(0);
    chk("fcnt_period", int'(fcnt), 2);

    // drop enable at (3,2): frame finishes, then idle
    run_to(1, 31);
    en = 1'b0;
    run_to(32, 97);
    step();
    check_idle("stop");
    chk("stop_fcnt", int'(fcnt), 2);
    step();
    check_idle("stop2");
    chk("stop2_fcnt", int'(fcnt), 2);

    // drop at (3,2), re-raise at (5,4)
    en = 1'b1;
    step();
    check_pos(0);
    chk("restart_fcnt", int'(fcnt), 3);
    run_to(1, 31);
    en = 1'b0;
    run_to(32, 61);
    en = 1'b1;
    run_to(62, 97);
    step();
    check_pos(0);
    chk("resume_fcnt", int'(fcnt), 4);

    // re-raise exactly on the last pixel while stopping
    run_to(1, 90);
    en = 1'b0;
    run_to(91, 97);
    en = 1'b1;
    step();
    check_pos(0);
    chk("lastpix_fcnt", int'(fcnt), 5);

    // asynchronous reset at (7,3)
    run_to(1, 49);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    chk("rst_mid_fcnt", int'(fcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_pos(0);
    chk("post_rst_fcnt", int'(fcnt), 1);

    // frame counter wrap
    run_to(1, 50);
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    chk("fcnt_preset", int'(fcnt), 65535);
    run_to(51, 97);
    step();
    check_pos(0);
    chk("fcnt_wrap", int'(fcnt), 0);
    run_to(1, 97);
    step();
    check_pos(0);
    chk("fcnt_after_wrap", int'(fcnt), 1);

    en = 1'b0;
    run_to(1, 97);
    step();
    check_idle("final");
    chk("final_fcnt", int'(fcnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch
- H_SYNC, 44, hsync width
- H_BP, 148, horizontal back porch
- V_ACTIVE, 1080, active lines
- V_FP, 4, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 36, vertical back porch
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level

REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- pixel_clk  in  1  pixel clock; single clock domain
- pixel_rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run request, level
- pixel_x  out  12  horizontal count h_cnt
- pixel_y  out  12  vertical count v_cnt
- pixel_de  out  1  active-video flag
- pixel_hs  out  1  hsync
- pixel_vs  out  1  vsync
- frame_start  out  1  one-cycle pulse at position (0,0)
- frame_cnt  out  16  frames started since reset
- busy  out  1  state != IDLE

REQ-003 One clock, pixel_clk; reset is asynchronous and active-low (pixel_rst_n); no other clock or reset.

REQ-004 All outputs SHALL be driven directly from flops; no combinational path from enable to any output.

Function
REQ-005 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; each SHALL be <= 4096 and each parameter >= 1.

REQ-006 FSM states:
- IDLE -> RUN when enable=1.
- RUN -> STOPPING when enable=0.
- STOPPING -> RUN when enable=1, counters undisturbed.
- STOPPING -> IDLE on the last pixel of the frame, i.e. after the cycle showing (H_TOTAL-1, V_TOTAL-1).

REQ-007 In IDLE:
- pixel_x=0, pixel_y=0, pixel_de=0.
- pixel_hs=~HS_POL, pixel_vs=~VS_POL.
- frame_start=0; frame_cnt holds.

REQ-008 The first cycle after the edge that samples enable=1 in IDLE SHALL present (0,0) with frame_start=1 (latency one cycle).

REQ-009 In RUN/STOPPING:
- pixel_x increments each cycle and wraps H_TOTAL-1 -> 0.
- On that wrap, pixel_y increments and wraps V_TOTAL-1 -> 0.

REQ-010 pixel_de=1 iff pixel_x < H_ACTIVE and pixel_y < V_ACTIVE, evaluated on the presented position.

REQ-011 pixel_hs=HS_POL iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC; else ~HS_POL.

REQ-012 pixel_vs=VS_POL iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC, for the whole line including blanking; else ~VS_POL.

REQ-013 frame_start=1 exactly on cycles presenting (0,0) while not IDLE; frame_cnt increments on the same cycle and wraps 0xFFFF -> 0.

REQ-014 The cycle after STOPPING -> IDLE SHALL show IDLE outputs, with no partial frame emitted.

REQ-015 enable toggling mid-frame SHALL never shorten, restart or skip a line or frame.

REQ-016 If enable=1 on the last-pixel cycle in STOPPING, the FSM SHALL remain in RUN and the next frame SHALL start seamlessly.

Reset
REQ-017 Asserting pixel_rst_n=0 SHALL immediately force:
- state=IDLE, pixel_x=0, pixel_y=0, pixel_de=0, frame_start=0, frame_cnt=0, busy=0.
- pixel_hs=~HS_POL, pixel_vs=~VS_POL.

REQ-018 Reset mid-frame SHALL abandon the frame; after release, the block SHALL behave as from power-up, starting a new frame at (0,0) when enable=1.

Verification
Bench parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), HS_POL=1, VS_POL=0.

REQ-019 Release reset with enable=1 held.
-> Cycle 1 shows (0,0), frame_start=1, frame_cnt=1.
-> 98-cycle frame period.
-> de high for 8 of every 14 cycles on lines 0..3 only, 32 de cycles per frame.

REQ-020 Steady run.
-> hs high at pixel_x=10,11.
-> vs low for all 14 cycles of pixel_y=5.
-> frame_start once every 98 cycles.

REQ-021 Drop enable at (3,2).
-> Outputs continue through (13,6).
-> Next cycle: IDLE outputs, busy=0, frame_cnt unchanged.

REQ-022 Drop enable at (3,2), re-raise at (5,4).
-> No discontinuity.
-> frame_start at the next (0,0).

REQ-023 Assert reset at (7,3).
-> Outputs go to IDLE values asynchronously, frame_cnt=0.
-> After release with enable=1: (0,0) on the first cycle.

REQ-024 Run 65536 frames, or force frame_cnt near wrap.
-> 0xFFFF -> 0 on the next frame_start.
